// File: rtl/dmem_dump_ctrl.sv
// dmem_dump_ctrl: on HALT_WORD, drains the pipeline, freezes the CPU, streams the data RAM out.
// Define DUMP_CHECKSUM_EN to accumulate a running sum of dumped words on dump_csum.
module dmem_dump_ctrl #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 9,
    parameter int DEPTH = 512,
    parameter int DRAIN_CYCLES = 5,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFFFFFF
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [DATA_W-1:0] instr_d,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              dump_valid,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W-1:0] dump_addr,
    input  logic              dump_ready,
    output logic              dump_done,
    output logic [DATA_W-1:0] dump_csum
);

    localparam int CNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(DRAIN_CYCLES - 1);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {RUN, DRAIN, READ, SEND, DONE} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_n;
    logic [DATA_W-1:0] data_q;
    logic              fresh;
    logic              stall_q;
    logic              cpu_owns;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= RUN;
            cnt     <= '0;
            rd_ptr  <= '0;
            data_q  <= '0;
            fresh   <= 1'b0;
            stall_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rd_ptr  <= rd_ptr_n;
            fresh   <= (state == READ);
            stall_q <= (state_n == READ) || (state_n == SEND) || (state_n == DONE);
            if (fresh) begin
                data_q <= ram_rdata;
            end
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        rd_ptr_n = rd_ptr;
        unique case (state)
            RUN: begin
                if (instr_d == HALT_WORD) begin
                    state_n = DRAIN;
                    cnt_n   = CNT_INIT;
                end
            end
            DRAIN: begin
                if (cnt == '0) begin
                    state_n  = READ;
                    rd_ptr_n = '0;
                end else begin
                    cnt_n = cnt - CNT_W'(1);
                end
            end
            READ: state_n = SEND;
            SEND: begin
                if (dump_ready) begin
                    if (rd_ptr == LAST) begin
                        state_n = DONE;
                    end else begin
                        state_n  = READ;
                        rd_ptr_n = rd_ptr + ADDR_W'(1);
                    end
                end
            end
            DONE: state_n = DONE;
            default: state_n = RUN;
        endcase
    end

    // The CPU keeps the RAM until the drain window has elapsed
    assign cpu_owns   = (state == RUN) || (state == DRAIN);
    assign ram_we     = cpu_owns & cpu_we;
    assign ram_addr   = cpu_owns ? cpu_addr : rd_ptr;
    assign ram_wdata  = cpu_wdata;
    assign cpu_rdata  = ram_rdata;
    assign cpu_stall  = stall_q;
    assign dump_valid = (state == SEND);
    assign dump_done  = (state == DONE);
    assign dump_addr  = rd_ptr;
    // First SEND cycle sees the read word directly; afterwards the held copy
    assign dump_data  = fresh ? ram_rdata : data_q;

`ifdef DUMP_CHECKSUM_EN
    logic [DATA_W-1:0] csum;
    logic              hs;

    assign hs = dump_valid & dump_ready;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            csum <= '0;
        end else if (hs) begin
            csum <= csum + dump_data;
        end
    end

    assign dump_csum = csum;
`else
    assign dump_csum = '0;
`endif

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Testbench for dmem_dump_ctrl: timeline/golden-memory model, randomized CPU traffic and backpressure.
// Build with or without DUMP_CHECKSUM_EN; the expected checksum follows the same macro.
module tb_dmem_dump_ctrl;

    localparam int DEPTH = 512;
    localparam int DC = 5;
    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic [31:0] instr_d;
    logic        cpu_we;
    logic [8:0]  cpu_addr;
    logic [31:0] cpu_wdata;
    logic [31:0] cpu_rdata;
    logic        cpu_stall;
    logic        ram_we;
    logic [8:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;
    logic        dump_valid;
    logic [31:0] dump_data;
    logic [8:0]  dump_addr;
    logic        dump_ready;
    logic        dump_done;
    logic [31:0] dump_csum;

    logic        preload = 1'b0;
    int          checks = 0;
    int          failures = 0;

    logic [31:0] mem [DEPTH];
    logic [31:0] gold [DEPTH];

    int          cyc = 0;
    bit          halted = 1'b0;
    int          halt_t = 0;
    int          sent = 0;
    int          next_valid = 0;
    logic [31:0] csum = '0;
    int          hs_total = 0;
    int          stall_rise = -1;
    int          done_rise = -1;
    logic [31:0] d3 = '0;

    always #5 CLK = ~CLK;

    dmem_dump_ctrl dut (
        .CLK        (CLK),
        .RST_N      (RST_N),
        .instr_d    (instr_d),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .dump_valid (dump_valid),
        .dump_data  (dump_data),
        .dump_addr  (dump_addr),
        .dump_ready (dump_ready),
        .dump_done  (dump_done),
        .dump_csum  (dump_csum)
    );

    // Single-port RAM with one-cycle synchronous read
    always @(posedge CLK) begin
        if (preload) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= 32'(i + 1);
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    // Model: phases derived from the halt cycle and the handshake count
    always begin
        @(negedge CLK);
        #2;
        begin : eval
            bit          own;
            bit          ev;
            logic [31:0] ecs;
            own = !halted || (cyc <= halt_t + DC);
            ev  = halted && (sent < DEPTH) && (cyc >= next_valid);
`ifdef DUMP_CHECKSUM_EN
            ecs = csum;
`else
            ecs = '0;
`endif
            chk("cpu_stall", 32'(cpu_stall), 32'(halted && cyc >= halt_t + DC + 1));
            chk("dump_valid", 32'(dump_valid), 32'(ev));
            chk("dump_done", 32'(dump_done), 32'(halted && sent == DEPTH));
            chk("dump_csum", dump_csum, ecs);
            chk("cpu_rdata", cpu_rdata, ram_rdata);
            if (own) begin
                chk("ram_we_cpu", 32'(ram_we), 32'(cpu_we));
                chk("ram_addr_cpu", 32'(ram_addr), 32'(cpu_addr));
                if (cpu_we) chk("ram_wdata", ram_wdata, cpu_wdata);
            end else begin
                chk("ram_we_ctrl", 32'(ram_we), 32'(0));
                if (sent < DEPTH && cyc == next_valid - 1)
                    chk("ram_addr_rd", 32'(ram_addr), 32'(sent));
            end
            if (ev) begin
                chk("dump_addr", 32'(dump_addr), 32'(sent));
                chk("dump_data", dump_data, gold[sent]);
            end else if (sent == 0) begin
                chk("idle_data", dump_data, 32'(0));
                chk("idle_addr", 32'(dump_addr), 32'(0));
            end

            if (RST_N) begin
                if (dump_valid && dump_ready) begin
                    hs_total++;
                    if (dump_addr == 9'd3) d3 = dump_data;
                end
                if (cpu_stall && stall_rise < 0) stall_rise = cyc;
                if (dump_done && done_rise < 0) done_rise = cyc;
            end
            if (own && cpu_we) gold[cpu_addr] = cpu_wdata;
            if (preload) begin
                for (int i = 0; i < DEPTH; i++) gold[i] = 32'(i + 1);
            end
            if (!RST_N) begin
                halted = 1'b0;
                sent = 0;
                csum = '0;
                hs_total = 0;
                stall_rise = -1;
                done_rise = -1;
                d3 = '0;
            end else begin
                if (!halted && instr_d == HALT) begin
                    halted = 1'b1;
                    halt_t = cyc;
                    next_valid = cyc + DC + 2;
                end
                if (ev && dump_ready) begin
                    csum = csum + gold[sent];
                    sent++;
                    next_valid = cyc + 2;
                end
            end
            cyc++;
        end
    end

    task automatic set_in(input logic rst, input logic [31:0] ins, input logic we,
                          input logic [8:0] a, input logic [31:0] wd, input logic rdy);
        RST_N = rst;
        instr_d = ins;
        cpu_we = we;
        cpu_addr = a;
        cpu_wdata = wd;
        dump_ready = rdy;
    endtask

    task automatic step(input logic rst, input logic [31:0] ins, input logic we,
                        input logic [8:0] a, input logic [31:0] wd, input logic rdy);
        @(negedge CLK);
        set_in(rst, ins, we, a, wd, rdy);
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] v;
        v = $urandom;
        if (v == HALT) v = 32'h0000_0013;
        return v;
    endfunction

    function automatic logic [8:0] rnd_addr();
        return 9'($urandom_range(0, DEPTH - 1));
    endfunction

    initial begin
        int  n;
        bit  hit;
        bit  bp_done;

        // Reset with the CPU driving a store
        set_in(1'b0, 32'h0, 1'b1, 9'h05, 32'h1234_5678, 1'b0);
        repeat (3) @(negedge CLK);
        #1;
        chk("rst_stall", 32'(cpu_stall), 32'(0));
        chk("rst_valid", 32'(dump_valid), 32'(0));
        chk("rst_done", 32'(dump_done), 32'(0));
        chk("rst_data", dump_data, 32'(0));
        chk("rst_addr", 32'(dump_addr), 32'(0));
        chk("rst_csum", dump_csum, 32'(0));
        chk("rst_ram_addr", 32'(ram_addr), 32'h005);
        chk("rst_ram_we", 32'(ram_we), 32'(1));

        @(negedge CLK);
        set_in(1'b1, 32'h0, 1'b0, 9'h0, 32'h0, 1'b1);
        preload = 1'b1;
        @(negedge CLK);
        preload = 1'b0;
        set_in(1'b1, rnd_instr(), 1'b0, rnd_addr(), $urandom, 1'b1);
        repeat (2) step(1'b1, rnd_instr(), 1'b0, rnd_addr(), $urandom, 1'b1);

        // Dump 1: ready always high, halt repeated during drain, CPU stores ignored
        step(1'b1, HALT, 1'b0, rnd_addr(), $urandom, 1'b1);
        repeat (DC) step(1'b1, HALT, 1'b0, rnd_addr(), $urandom, 1'b1);
        n = 0;
        do begin
            step(1'b1, $urandom, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'b1);
            n++;
        end while (!dump_done && n < 1500);
        #3;
        chk("d1_done", 32'(dump_done), 32'(1));
        chk("d1_stall_delay", 32'(stall_rise - halt_t), 32'(6));
        chk("d1_handshakes", 32'(hs_total), 32'(512));
        chk("d1_done_delay", 32'(done_rise - (halt_t + DC + 1)), 32'(1024));
`ifdef DUMP_CHECKSUM_EN
        chk("d1_csum", dump_csum, 32'h0002_0100);
`endif

        step(1'b0, 32'h0, 1'b0, 9'h0, 32'h0, 1'b0);
        step(1'b0, 32'h0, 1'b0, 9'h0, 32'h0, 1'b0);

        // Dump 2: random traffic, store right after halt, backpressure, reset mid-dump
        repeat (30) step(1'b1, rnd_instr(), 1'($urandom_range(0, 1)), rnd_addr(),
                         $urandom, 1'($urandom_range(0, 1)));
        step(1'b1, HALT, 1'b0, rnd_addr(), $urandom, 1'b1);
        step(1'b1, HALT, 1'b1, 9'd3, 32'hDEAD_BEEF, 1'b1);
        repeat (DC - 1) step(1'b1, rnd_instr(), 1'($urandom_range(0, 1)),
                             9'($urandom_range(16, DEPTH - 1)), $urandom, 1'b1);
        n = 0;
        hit = 1'b0;
        bp_done = 1'b0;
        while (!hit && n < 3000) begin
            @(negedge CLK);
            n++;
            if (dump_valid && dump_addr == 9'd200) begin
                hit = 1'b1;
                chk("d2_hs_before_rst", 32'(hs_total), 32'(200));
                chk("d2_addr3_word", d3, 32'hDEAD_BEEF);
                set_in(1'b0, 32'h0, 1'b1, rnd_addr(), $urandom, 1'b1);
            end else if (!bp_done && dump_valid && dump_addr == 9'd10) begin
                bp_done = 1'b1;
                set_in(1'b1, $urandom, 1'($urandom_range(0, 1)), rnd_addr(), $urandom, 1'b0);
                for (int k = 0; k < 6; k++) begin
                    @(negedge CLK);
                    set_in(1'b1, $urandom, 1'b1, rnd_addr(), $urandom, 1'b0);
                    #1;
                    chk("bp_valid", 32'(dump_valid), 32'(1));
                    chk("bp_addr", 32'(dump_addr), 32'd10);
                end
            end else begin
                set_in(1'b1, $urandom, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                       1'($urandom_range(0, 3) != 0));
            end
        end
        chk("d2_reached_200", 32'(hit), 32'(1));
        step(1'b1, rnd_instr(), 1'b0, rnd_addr(), $urandom, 1'b1);
        #1;
        chk("d2_rst_stall", 32'(cpu_stall), 32'(0));
        chk("d2_rst_valid", 32'(dump_valid), 32'(0));

        // Dump 3: restart after mid-dump reset, random backpressure to completion
        repeat (4) step(1'b1, rnd_instr(), 1'($urandom_range(0, 1)), rnd_addr(),
                        $urandom, 1'b1);
        step(1'b1, HALT, 1'b0, rnd_addr(), $urandom, 1'b1);
        n = 0;
        do begin
            step(1'b1, $urandom, 1'($urandom_range(0, 1)), rnd_addr(), $urandom,
                 1'($urandom_range(0, 3) != 0));
            n++;
        end while (!dump_done && n < 3000);
        #3;
        chk("d3_done", 32'(dump_done), 32'(1));
        chk("d3_handshakes", 32'(hs_total), 32'(512));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_dump_ctrl.md
# dmem_dump_ctrl

End-of-program controller for the pipelined CPU's data memory. Detects the halt word (32'hFFFFFFFF) in the decode stage, lets the pipeline drain for a fixed number of cycles, then freezes the CPU, takes ownership of the single-port data RAM, and streams every word (address 0 to DEPTH-1) out over a valid/ready port. It sits between the CPU memory stage and the data RAM, muxing the RAM port between the two owners.

## Interface
- DATA_W, 32, data word width
- ADDR_W, 9, RAM word-address width
- DEPTH, 512, number of words dumped; must be ≤ 2^ADDR_W and ≥ 1
- DRAIN_CYCLES, 5, cycles between halt detection and RAM takeover; must be ≥ 1
- HALT_WORD, 32'hFFFFFFFF, decode-stage instruction that triggers the dump

- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset; synchronous, active-low
- instr_d  in  DATA_W  decode-stage instruction
- cpu_we  in  1  CPU memory-stage write enable
- cpu_addr  in  ADDR_W  CPU word address
- cpu_wdata  in  DATA_W  CPU write data
- cpu_rdata  out  DATA_W  RAM read data returned to CPU (= ram_rdata, passthrough)
- cpu_stall  out  1  freezes the whole CPU pipeline
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_W  RAM address
- ram_wdata  out  DATA_W  RAM write data
- ram_rdata  in  DATA_W  RAM read data; synchronous read, valid one cycle after ram_addr
- dump_valid  out  1  dump_data/dump_addr valid
- dump_data  out  DATA_W  dumped word
- dump_addr  out  ADDR_W  address of dumped word
- dump_ready  in  1  consumer accepts word
- dump_done  out  1  all DEPTH words transferred
- dump_csum  out  DATA_W  running checksum (see Configuration)

## Operation
- States: RUN, DRAIN, READ, SEND, DONE.
- RUN: CPU owns RAM (ram_* = cpu_*). cpu_stall=0. If instr_d == HALT_WORD → DRAIN, drain counter loaded with DRAIN_CYCLES-1.
- DRAIN: CPU still owns RAM, cpu_stall=0, so in-flight stores commit. Counter decrements each cycle; at 0 → READ with rd_ptr=0. instr_d is ignored in DRAIN.
- READ: controller owns RAM. ram_we=0, ram_addr=rd_ptr, cpu_stall=1. Always → SEND next cycle.
- SEND: dump_data registers ram_rdata on entry and holds it; dump_addr=rd_ptr; dump_valid=1. Holds while dump_ready=0. On dump_valid&&dump_ready: if rd_ptr == DEPTH-1 → DONE; else rd_ptr+1 → READ.
- DONE: dump_done=1, cpu_stall=1, ram_we=0, dump_valid=0. Terminal until reset.
- From READ onward the CPU is never given the RAM and cpu_we is ignored (ram_we forced 0).
- rd_ptr is ADDR_W bits; the terminal compare is against DEPTH-1, so DEPTH = 2^ADDR_W terminates without wrap.

## Timing
- Reset (RST_N=0 at a rising edge, any state including mid-drain or mid-SEND): state=RUN, rd_ptr=0, counter=0, cpu_stall=0, dump_valid=0, dump_data=0, dump_addr=0, dump_done=0, dump_csum=0. RAM mux returns to CPU combinationally from the next cycle.
- Halt seen in cycle T: DRAIN for cycles T+1 … T+DRAIN_CYCLES; cpu_stall rises and first RAM read issued in cycle T+DRAIN_CYCLES+1; dump_valid first high in T+DRAIN_CYCLES+2.
- Per word: 2 cycles minimum (READ + SEND) with dump_ready held high; full dump = 2·DEPTH cycles after the first READ.
- dump_data, dump_addr stable while dump_valid=1 && dump_ready=0. dump_valid never drops without a handshake.
- dump_done asserts the cycle after the final handshake.
- cpu_stall is registered from state; ram_* mux is combinational on state.

## Configuration
- DUMP_CHECKSUM_EN defined: dump_csum accumulates (mod 2^DATA_W) the sum of every word at its handshake; final value valid when dump_done=1; cleared by reset.
- Not defined: accumulator omitted; dump_csum tied to 0.

## Test plan
- Reset/idle: hold RST_N=0 3 cycles, instr_d=0 → all outputs 0, ram_addr follows cpu_addr=9'h05, ram_we follows cpu_we=1.
- Drain commit: CPU writes 32'hDEADBEEF to addr 3 in the cycle after halt seen → word committed (ram_we=1 during DRAIN); dump later shows addr 3 = 32'hDEADBEEF; cpu_stall rises exactly DRAIN_CYCLES+1=6 cycles after halt.
- Full dump, dump_ready=1 constant, RAM preloaded with addr+1 → 512 handshakes, dump_addr 0…511 in order, dump_data 1…512, dump_done high 1024 cycles after first READ; with DUMP_CHECKSUM_EN, dump_csum = 131328 (32'h00020100).
- Backpressure: dump_ready low for 7 cycles during addr 10 → dump_valid stays 1, dump_data/dump_addr unchanged, no skip or duplicate of addr 10/11.
- Reset mid-dump: RST_N=0 during SEND at addr 200 → next cycle RUN, cpu_stall=0, dump_valid=0; subsequent halt restarts dump from addr 0.
- Halt word repeated in DRAIN and cpu_we=1 during READ/SEND → no counter reload, ram_we stays 0, RAM contents unchanged.
